// File: rtl/pixie_dp_frame_buffer_pp_if.sv
// Pixie ping-pong frame buffer bus bundle.
// Groups the write, read, swap and clear signals of pixie_dp_frame_buffer_pp.
//   master : the DMA/CPU and scan-out side (drives requests, receives status)
//   slave  : the frame buffer itself
// Signals:
//   wr_en/wr_addr/wr_data  write into the back bank
//   rd_en/rd_addr          read request on the front bank
//   rd_data/rd_valid       registered read result, one cycle later
//   swap_req/swap_ack      bank exchange request and one-cycle acknowledge
//   clear_req/clear_busy   start / progress of the back-bank fill
//   wr_drop                pulse when a write was discarded
//   front_bank             bank index currently being scanned out
interface pixie_dp_frame_buffer_pp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              swap_req;
  logic              swap_ack;
  logic              clear_req;
  logic              clear_busy;
  logic              wr_drop;
  logic              front_bank;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, clear_req,
    input  rd_data, rd_valid, swap_ack, clear_busy, wr_drop, front_bank
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req, clear_req,
    output rd_data, rd_valid, swap_ack, clear_busy, wr_drop, front_bank
  );
endinterface

// File: rtl/pixie_dp_frame_buffer_pp.sv
// Pixie double-buffered (ping-pong) frame buffer.
// The DMA/CPU side writes the back bank while scan-out reads the front bank.
// A swap request exchanges the banks when no clear is running; a clear request
// fills the whole back bank with CLEAR_VAL, one word per cycle.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset (RAM contents are kept)
//   bus      pixie_dp_frame_buffer_pp_if.slave, see the interface for signals
module pixie_dp_frame_buffer_pp #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 10,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic                       clk,
  input logic                       reset_n,
  pixie_dp_frame_buffer_pp_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  // Address arithmetic is done one bit wider than a bank address so that
  // DEPTH itself and bank-offset addresses are representable.
  localparam int                PA_W     = ADDR_W + 1;
  localparam int                MEM_AW   = $clog2(2 * DEPTH);
  localparam logic [PA_W-1:0]   DEPTH_P  = PA_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [2*DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clear_cnt;
  logic              swap_pending;
  logic              front_q;
  logic              clear_busy_q;
  logic              swap_ack_q;
  logic              wr_drop_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              wr_oor;
  logic              rd_oor;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Bank 1 sits DEPTH words above bank 0, so storage is exactly 2*DEPTH
  // words even when DEPTH is smaller than 2**ADDR_W.
  function automatic logic [MEM_AW-1:0] phys(input logic bank,
                                             input logic [ADDR_W-1:0] a);
    logic [PA_W-1:0] p;
    p = bank ? (DEPTH_P + {1'b0, a}) : {1'b0, a};
    return MEM_AW'(p);
  endfunction

  assign wr_oor = ({1'b0, bus.wr_addr} >= DEPTH_P);
  assign rd_oor = ({1'b0, bus.rd_addr} >= DEPTH_P);

  // Single RAM write port: the clear engine owns it for the whole clear,
  // which is why host writes are dropped while clear_busy is high.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = phys(~front_q, bus.wr_addr);
    mem_wdata = bus.wr_data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = phys(~front_q, clear_cnt);
      mem_wdata = CLEAR_VAL;
    end else if (bus.wr_en && !wr_oor) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      clear_cnt    <= '0;
      swap_pending <= 1'b0;
      front_q      <= 1'b0;
      clear_busy_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      wr_drop_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      // Read uses the front bank as it was before this edge, even on a swap edge.
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_oor ? CLEAR_VAL : mem[phys(front_q, bus.rd_addr)];
      end

      wr_drop_q  <= bus.wr_en && (wr_oor || clear_busy_q);
      swap_ack_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            // A clear starting now beats a swap; the swap waits for it.
            state        <= CLEAR;
            clear_cnt    <= '0;
            clear_busy_q <= 1'b1;
            swap_pending <= swap_pending | bus.swap_req;
          end else if (swap_pending || bus.swap_req) begin
            front_q      <= ~front_q;
            swap_pending <= 1'b0;
            swap_ack_q   <= 1'b1;
          end
        end
        CLEAR: begin
          swap_pending <= swap_pending | bus.swap_req;
          if (clear_cnt == LAST_IDX) begin
            state        <= IDLE;
            clear_busy_q <= 1'b0;
          end else begin
            clear_cnt <= clear_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.wr_drop    = wr_drop_q;
  assign bus.front_bank = front_q;
endmodule

// File: tb/tb_pixie_dp_frame_buffer_pp.sv
// Bench for pixie_dp_frame_buffer_pp: directed scenarios with literal
// expectations, then random traffic, all compared every cycle against a
// bank-level behavioural model.
module tb_pixie_dp_frame_buffer_pp;
  localparam int          DATA_W    = 8;
  localparam int          ADDR_W    = 5;
  localparam int          DEPTH     = 16;
  localparam logic [7:0]  CLEAR_VAL = 8'hFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pixie_dp_frame_buffer_pp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pixie_dp_frame_buffer_pp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Banks are plain arrays; a clear fills the whole back bank at once, which
  // is observably equivalent because the back bank cannot be read until a
  // swap, and no swap happens before the clear has finished.
  logic [7:0] m_mem   [2][DEPTH];
  bit         m_known [2][DEPTH];
  bit         m_front;
  bit         m_pending;
  int         m_clear_left;
  logic [7:0] e_data;
  bit         e_data_known;
  bit         e_valid, e_ack, e_drop;

  always @(posedge clk or negedge reset_n) begin
    bit busy;
    if (!reset_n) begin
      if (m_clear_left > 0) begin
        for (int i = 0; i < DEPTH; i++) m_known[int'(!m_front)][i] = 1'b0;
      end
      m_front      = 1'b0;
      m_pending    = 1'b0;
      m_clear_left = 0;
      e_data       = 8'h00;
      e_data_known = 1'b1;
      e_valid      = 1'b0;
      e_ack        = 1'b0;
      e_drop       = 1'b0;
    end else begin
      busy    = (m_clear_left > 0);
      e_valid = bus.rd_en;
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) >= DEPTH) begin
          e_data       = CLEAR_VAL;
          e_data_known = 1'b1;
        end else begin
          e_data       = m_mem[int'(m_front)][int'(bus.rd_addr)];
          e_data_known = m_known[int'(m_front)][int'(bus.rd_addr)];
        end
      end
      e_drop = bus.wr_en && ((int'(bus.wr_addr) >= DEPTH) || busy);
      if (bus.wr_en && !e_drop) begin
        m_mem[int'(!m_front)][int'(bus.wr_addr)]   = bus.wr_data;
        m_known[int'(!m_front)][int'(bus.wr_addr)] = 1'b1;
      end
      e_ack = 1'b0;
      if (busy) begin
        m_clear_left--;
        m_pending = m_pending | bus.swap_req;
      end else if (bus.clear_req) begin
        m_clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[int'(!m_front)][i]   = CLEAR_VAL;
          m_known[int'(!m_front)][i] = 1'b1;
        end
        m_pending = m_pending | bus.swap_req;
      end else if (m_pending || bus.swap_req) begin
        m_front   = !m_front;
        m_pending = 1'b0;
        e_ack     = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("m_front_bank", 32'(bus.front_bank), 32'(m_front));
      check("m_rd_valid",   32'(bus.rd_valid),   32'(e_valid));
      check("m_swap_ack",   32'(bus.swap_ack),   32'(e_ack));
      check("m_clear_busy", 32'(bus.clear_busy), 32'(m_clear_left > 0));
      check("m_wr_drop",    32'(bus.wr_drop),    32'(e_drop));
      if (e_data_known) check("m_rd_data", 32'(bus.rd_data), 32'(e_data));
    end
  end

  task automatic clr_inputs();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.swap_req  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    repeat (n) begin
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = 5'($urandom_range(0, DEPTH + 3));
      bus.wr_data   = 8'($urandom);
      bus.rd_en     = 1'($urandom_range(0, 1));
      bus.rd_addr   = 5'($urandom_range(0, DEPTH + 3));
      bus.swap_req  = ($urandom_range(0, 7) == 0);
      bus.clear_req = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    clr_inputs();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cnt;
    int drops;
    clr_inputs();
    repeat (3) @(negedge clk);
    check("rst_front",    32'(bus.front_bank), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid),   32'd0);
    check("rst_rd_data",  32'(bus.rd_data),    32'd0);
    check("rst_busy",     32'(bus.clear_busy), 32'd0);
    check("rst_ack",      32'(bus.swap_ack),   32'd0);
    reset_n = 1'b1;

    // Write back bank, swap, read it back from the front.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_addr = 5'd3; bus.wr_data = 8'h33;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    check("t1_swap_ack", 32'(bus.swap_ack),   32'd1);
    check("t1_front",    32'(bus.front_bank), 32'd1);
    bus.rd_en = 1'b1; bus.rd_addr = 5'd5;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("t1_ack_one_cycle", 32'(bus.swap_ack), 32'd0);
    check("t1_rd_data",       32'(bus.rd_data),  32'hA5);
    check("t1_rd_valid",      32'(bus.rd_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_low", 32'(bus.rd_valid), 32'd0);
    check("t1_data_hold", 32'(bus.rd_data),  32'hA5);

    // Write to back without swap: read returns the front content.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'h11;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t2_no_drop", 32'(bus.wr_drop), 32'd0);
    bus.rd_en = 1'b1; bus.rd_addr = 5'd3;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("t2_rd_front", 32'(bus.rd_data),  32'h33);
    check("t2_rd_valid", 32'(bus.rd_valid), 32'd1);

    // Clear with writes attempted throughout.
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    cnt = 0; drops = 0;
    while (bus.clear_busy && cnt < 40) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'($urandom_range(0, DEPTH - 1));
      bus.wr_data = 8'($urandom);
      @(negedge clk);
      cnt++;
      if (bus.wr_drop) drops++;
    end
    bus.wr_en = 1'b0;
    check("t3_busy_cycles", 32'(cnt),   32'd16);
    check("t3_drops",       32'(drops), 32'd16);
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    check("t3_front", 32'(bus.front_bank), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en = 1'b1; bus.rd_addr = 5'(i);
      @(negedge clk);
      check("t3_cleared", 32'(bus.rd_data), 32'hFF);
    end
    bus.rd_en = 1'b0;

    // Simultaneous swap and clear: clear first, swap right after.
    bus.clear_req = 1'b1; bus.swap_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0; bus.swap_req = 1'b0;
    cnt = 0;
    while (bus.clear_busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_busy_cycles", 32'(cnt),           32'd16);
    check("t4_no_ack_yet",  32'(bus.swap_ack),   32'd0);
    check("t4_front_hold",  32'(bus.front_bank), 32'd0);
    @(negedge clk);
    check("t4_ack",         32'(bus.swap_ack),   32'd1);
    check("t4_front",       32'(bus.front_bank), 32'd1);
    @(negedge clk);
    check("t4_ack_once",    32'(bus.swap_ack),   32'd0);
    check("t4_front_once",  32'(bus.front_bank), 32'd1);

    // Out-of-range write and read.
    bus.wr_en = 1'b1; bus.wr_addr = 5'(DEPTH);     bus.wr_data = 8'h5A;
    bus.rd_en = 1'b1; bus.rd_addr = 5'(DEPTH + 2);
    @(negedge clk);
    clr_inputs();
    check("t5_drop",     32'(bus.wr_drop),  32'd1);
    check("t5_rd_data",  32'(bus.rd_data),  32'(CLEAR_VAL));
    check("t5_rd_valid", 32'(bus.rd_valid), 32'd1);
    bus.rd_en = 1'b1; bus.rd_addr = 5'd0;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("t5_ram_kept", 32'(bus.rd_data), 32'hFF);

    random_cycles(3000);

    // Asynchronous reset in the middle of a clear and a read burst.
    cnt = 0;
    while (bus.clear_busy && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.front_bank) begin
      bus.swap_req = 1'b1;
      @(negedge clk);
      bus.swap_req = 1'b0;
    end
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr = 5'd1;
    repeat (5) @(negedge clk);
    check("t6_pre_busy",  32'(bus.clear_busy), 32'd1);
    check("t6_pre_front", 32'(bus.front_bank), 32'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_data",  32'(bus.rd_data),    32'd0);
    check("t6_async_valid", 32'(bus.rd_valid),   32'd0);
    check("t6_async_busy",  32'(bus.clear_busy), 32'd0);
    check("t6_async_front", 32'(bus.front_bank), 32'd0);
    check("t6_async_ack",   32'(bus.swap_ack),   32'd0);
    check("t6_async_drop",  32'(bus.wr_drop),    32'd0);
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_idle_busy",  32'(bus.clear_busy), 32'd0);
    check("t6_idle_front", 32'(bus.front_bank), 32'd0);

    random_cycles(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
